// File: rtl/cachemem_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin AR grant, a single burst in flight,
// and R beats steered back to the requester that owns the current burst.
module cachemem_rd_arbiter #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S0_ARADDR,
    input  logic [7:0]                         S0_ARLEN,
    input  logic                               S0_ARVALID,
    output logic                               S0_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S0_RDATA,
    output logic                               S0_RLAST,
    output logic                               S0_RVALID,
    input  logic                               S0_RREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S1_ARADDR,
    input  logic [7:0]                         S1_ARLEN,
    input  logic                               S1_ARVALID,
    output logic                               S1_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S1_RDATA,
    output logic                               S1_RLAST,
    output logic                               S1_RVALID,
    input  logic                               S1_RREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic [1:0]                         M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [0:0]                         M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [3:0]                         M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [1:0]                         GRANT,
    output logic                               BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      grant_q, grant_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                      arlen_q, arlen_d;
    logic                            arvalid_q, arvalid_d;
    logic                            prio_q, prio_d;
    logic                            win;
    logic                            ar_hs;
    logic                            m_rready;
    logic                            unused_ok;

    // Single-ID master: RID, RRESP and RUSER carry nothing this block acts on.
    assign unused_ok = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_RUSER};

    // Winner index: a lone requester wins, a tie goes to the pointer.
    assign win   = (S0_ARVALID && S1_ARVALID) ? prio_q : S1_ARVALID;
    assign ar_hs = arvalid_q && M_AXI_ARREADY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            prio_q    <= prio_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        prio_d    = prio_q;
        case (state_q)
            S_IDLE: begin
                if (S0_ARVALID || S1_ARVALID) begin
                    state_d   = S_ADDR;
                    grant_d   = win ? 2'b10 : 2'b01;
                    araddr_d  = win ? S1_ARADDR : S0_ARADDR;
                    arlen_d   = win ? S1_ARLEN : S0_ARLEN;
                    arvalid_d = 1'b1;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    state_d   = S_DATA;
                    arvalid_d = 1'b0;
                end
            end
            S_DATA: begin
                if (M_AXI_RVALID && m_rready && M_AXI_RLAST) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    prio_d  = grant_q[0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        S0_ARREADY = 1'b0;
        S1_ARREADY = 1'b0;
        S0_RDATA   = '0;
        S0_RLAST   = 1'b0;
        S0_RVALID  = 1'b0;
        S1_RDATA   = '0;
        S1_RLAST   = 1'b0;
        S1_RVALID  = 1'b0;
        m_rready   = 1'b0;
        if (state_q == S_ADDR) begin
            S0_ARREADY = grant_q[0] && ar_hs;
            S1_ARREADY = grant_q[1] && ar_hs;
        end
        if (state_q == S_DATA) begin
            if (grant_q[0]) begin
                S0_RDATA  = M_AXI_RDATA;
                S0_RLAST  = M_AXI_RLAST;
                S0_RVALID = M_AXI_RVALID;
                m_rready  = S0_RREADY;
            end
            if (grant_q[1]) begin
                S1_RDATA  = M_AXI_RDATA;
                S1_RLAST  = M_AXI_RLAST;
                S1_RVALID = M_AXI_RVALID;
                m_rready  = S1_RREADY;
            end
        end
    end

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 2'b00;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = m_rready;
    assign GRANT         = grant_q;
    assign BUSY          = (state_q != S_IDLE);

endmodule

// File: tb/tb_cachemem_rd_arbiter.sv
// Bench for cachemem_rd_arbiter: behavioural AXI read slave, arbitration vector table,
// and an R-beat scoreboard filled when requests are driven and drained by a monitor.
module tb_cachemem_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [AW-1:0] S0_ARADDR = '0, S1_ARADDR = '0;
    logic [7:0]    S0_ARLEN = '0, S1_ARLEN = '0;
    logic          S0_ARVALID = 1'b0, S1_ARVALID = 1'b0;
    logic          S0_ARREADY, S1_ARREADY;
    logic [DW-1:0] S0_RDATA, S1_RDATA;
    logic          S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID;
    logic          S0_RREADY = 1'b1, S1_RREADY = 1'b1;
    logic [IW-1:0] M_AXI_ARID;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]    M_AXI_ARBURST, M_AXI_ARLOCK;
    logic [3:0]    M_AXI_ARCACHE, M_AXI_ARQOS;
    logic [0:0]    M_AXI_ARUSER;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [IW-1:0] M_AXI_RID = '0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = '0;
    logic          M_AXI_RLAST = 1'b0;
    logic [3:0]    M_AXI_RUSER = '0;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;
    logic [1:0]    GRANT;
    logic          BUSY;

    cachemem_rd_arbiter #(
        .C_M_AXI_THREAD_ID_WIDTH(IW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RDATA(S1_RDATA), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY), .GRANT(GRANT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [DW-1:0] data; logic last; } rbeat_t;
    typedef struct { int req; logic [DW-1:0] data; logic last; } exp_t;
    typedef struct {
        bit s0v; bit s1v; logic [AW-1:0] a0; logic [AW-1:0] a1; logic [7:0] len;
        logic [1:0] exp_grant; logic [AW-1:0] exp_addr;
    } vec_t;

    rbeat_t        rq[$];
    exp_t          sb[$];
    vec_t          tbl[8];
    int            nvec = 0;
    int            nerr = 0;
    int            rx_cnt[2];
    int            ar_delay = 0;
    int            ar_cnt = 0;
    logic [DW-1:0] data_off = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic take(input int req, input logic [DW-1:0] d, input logic l);
        exp_t e;
        rx_cnt[req]++;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_beat: S%0d got 0x%0h, want no beat", req, d);
        end else begin
            e = sb.pop_front();
            chk("beat_req", req, e.req);
            chk("beat_data", d, e.data);
            chk("beat_last", l, e.last);
        end
    endtask

    // R monitor: every accepted upstream beat must be the next scoreboard entry.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rvalid_exclusive", S0_RVALID & S1_RVALID, 0);
            if (S0_RVALID && S0_RREADY) take(0, S0_RDATA, S0_RLAST);
            if (S1_RVALID && S1_RREADY) take(1, S1_RDATA, S1_RLAST);
        end
    end

    // One clock: note handshakes mid-cycle, then advance the slave model after the edge.
    task automatic cycle();
        bit ar_hs, r_hs;
        logic [AW-1:0] ar_addr;
        logic [7:0] ar_len;
        @(negedge CLK);
        ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
        r_hs    = M_AXI_RVALID && M_AXI_RREADY;
        ar_addr = M_AXI_ARADDR;
        ar_len  = M_AXI_ARLEN;
        @(posedge CLK);
        #1;
        if (r_hs && rq.size() != 0) void'(rq.pop_front());
        if (ar_hs)
            for (int i = 0; i <= int'(ar_len); i++)
                rq.push_back('{ar_addr + DW'(i) + data_off, (i == int'(ar_len))});
        M_AXI_RVALID = (rq.size() != 0);
        M_AXI_RDATA  = (rq.size() != 0) ? rq[0].data : '0;
        M_AXI_RLAST  = (rq.size() != 0) ? rq[0].last : 1'b0;
        if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
            M_AXI_ARREADY = (ar_cnt >= ar_delay);
            ar_cnt++;
        end else begin
            M_AXI_ARREADY = 1'b0;
            ar_cnt = 0;
        end
        #1;
    endtask

    task automatic push_burst(input int req, input logic [DW-1:0] base, input int len);
        for (int i = 0; i <= len; i++) sb.push_back('{req, base + DW'(i), (i == len)});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        S0_ARVALID = 1'b0;
        S1_ARVALID = 1'b0;
        rq.delete();
        sb.delete();
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    // Wait for the requester's ARREADY pulse, take the handshake edge, then drop its ARVALID.
    task automatic wait_ar(input int req, output int n);
        n = 0;
        while (!(req == 0 ? S0_ARREADY : S1_ARREADY) && n < 100) begin
            cycle();
            n++;
        end
        chk("ar_handshake_seen", (n < 100), 1);
        chk("arready_loser", (req == 0 ? S1_ARREADY : S0_ARREADY), 0);
        cycle();
        chk("arready_single_pulse", (req == 0 ? S0_ARREADY : S1_ARREADY), 0);
        chk("arvalid_cleared", M_AXI_ARVALID, 0);
        if (req == 0) S0_ARVALID = 1'b0;
        else S1_ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 500) begin
            cycle();
            n++;
        end
        chk("burst_end_idle", BUSY, 0);
    endtask

    // Both requesters assert together; 'first' must win, 'second' follows after one idle cycle.
    task automatic pair(input int first);
        int second, n, idle;
        second = 1 - first;
        push_burst(first, first ? 32'h8000 : 32'h1000, 31);
        push_burst(second, second ? 32'h8000 : 32'h1000, 31);
        S0_ARADDR = 32'h1000; S1_ARADDR = 32'h8000;
        S0_ARLEN = 8'h1F; S1_ARLEN = 8'h1F;
        S0_ARVALID = 1'b1; S1_ARVALID = 1'b1;
        cycle();
        chk("pair_grant_first", GRANT, first ? 2'b10 : 2'b01);
        wait_ar(first, n);
        wait_idle();
        idle = 0;
        while (!M_AXI_ARVALID && idle < 10) begin
            idle++;
            cycle();
        end
        chk("pair_idle_gap", idle, 1);
        chk("pair_grant_second", GRANT, second ? 2'b10 : 2'b01);
        chk("pair_addr_second", M_AXI_ARADDR, second ? 32'h8000 : 32'h1000);
        wait_ar(second, n);
        wait_idle();
        chk("pair_sb_drained", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        vec_t v;
        int w;

        tbl[0] = '{1'b1, 1'b0, 32'h100, 32'hDEAD0000, 8'd0, 2'b01, 32'h100};
        tbl[1] = '{1'b0, 1'b1, 32'hDEAD0000, 32'h200, 8'd1, 2'b10, 32'h200};
        tbl[2] = '{1'b1, 1'b1, 32'h300, 32'h400, 8'd3, 2'b01, 32'h300};
        tbl[3] = '{1'b1, 1'b1, 32'h500, 32'h600, 8'd0, 2'b10, 32'h600};
        tbl[4] = '{1'b0, 1'b1, 32'hDEAD0000, 32'h700, 8'd2, 2'b10, 32'h700};
        tbl[5] = '{1'b1, 1'b1, 32'h800, 32'h900, 8'd1, 2'b01, 32'h800};
        tbl[6] = '{1'b1, 1'b0, 32'hA00, 32'hDEAD0000, 8'd0, 2'b01, 32'hA00};
        tbl[7] = '{1'b1, 1'b1, 32'hB00, 32'hC00, 8'd3, 2'b10, 32'hC00};

        do_reset();
        chk("rst_grant", GRANT, 2'b00);
        chk("rst_busy", BUSY, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_araddr", M_AXI_ARADDR, 0);
        chk("rst_arlen", M_AXI_ARLEN, 0);
        chk("rst_arready", {S0_ARREADY, S1_ARREADY}, 0);
        chk("rst_rvalid", {S0_RVALID, S1_RVALID}, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("ar_constants", {M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE,
                             M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER},
            {1'b0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 1'b0});

        // Arbitration table, starting from the reset pointer.
        for (int k = 0; k < 8; k++) begin
            v = tbl[k];
            w = v.exp_grant[1] ? 1 : 0;
            push_burst(w, v.exp_addr, int'(v.len));
            S0_ARADDR = v.a0; S1_ARADDR = v.a1;
            S0_ARLEN = v.len; S1_ARLEN = v.len;
            S0_ARVALID = v.s0v; S1_ARVALID = v.s1v;
            #1;
            chk("tbl_arvalid_before_edge", M_AXI_ARVALID, 0);
            cycle();
            chk("tbl_arvalid", M_AXI_ARVALID, 1);
            chk("tbl_grant", GRANT, v.exp_grant);
            chk("tbl_araddr", M_AXI_ARADDR, v.exp_addr);
            chk("tbl_arlen", M_AXI_ARLEN, v.len);
            wait_ar(w, n);
            S0_ARVALID = 1'b0; S1_ARVALID = 1'b0;
            wait_idle();
            chk("tbl_grant_idle", GRANT, 2'b00);
            chk("tbl_sb_drained", sb.size(), 0);
        end

        pair(0);

        // Lone S0 burst of 32 beats carrying 0..31, slave accepts after 2 cycles.
        ar_delay = 2;
        data_off = 32'hFFFF_F000;
        base = rx_cnt[1];
        push_burst(0, 32'h0, 31);
        S0_ARADDR = 32'h1000; S0_ARLEN = 8'h1F; S0_ARVALID = 1'b1;
        cycle();
        chk("t1_arvalid_latency", M_AXI_ARVALID, 1);
        chk("t1_grant", GRANT, 2'b01);
        chk("t1_araddr", M_AXI_ARADDR, 32'h1000);
        chk("t1_arlen", M_AXI_ARLEN, 8'h1F);
        wait_ar(0, n);
        chk("t1_ar_wait", n, 2);
        wait_idle();
        chk("t1_grant_after", GRANT, 2'b00);
        chk("t1_sb_drained", sb.size(), 0);
        chk("t1_s1_quiet", rx_cnt[1] - base, 0);
        ar_delay = 0;
        data_off = '0;

        pair(1);

        // S1 stalls its R channel for 3 cycles after beat 10.
        push_burst(1, 32'h3000, 31);
        S1_ARADDR = 32'h3000; S1_ARLEN = 8'h1F; S1_ARVALID = 1'b1;
        cycle();
        wait_ar(1, n);
        base = rx_cnt[1];
        n = 0;
        while (rx_cnt[1] - base < 10 && n < 100) begin
            cycle();
            n++;
        end
        S1_RREADY = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_m_rready", M_AXI_RREADY, 0);
            chk("stall_held_data", {S1_RVALID, S1_RDATA}, {1'b1, 32'h300A});
            cycle();
        end
        chk("stall_no_beat", rx_cnt[1] - base, 10);
        S1_RREADY = 1'b1;
        wait_idle();
        chk("stall_beat_total", rx_cnt[1] - base, 32);
        chk("stall_sb_drained", sb.size(), 0);

        // Single-beat burst from S1.
        data_off = 32'hDEADBEEF - 32'h2000;
        push_burst(1, 32'hDEADBEEF, 0);
        S1_ARADDR = 32'h2000; S1_ARLEN = 8'h00; S1_ARVALID = 1'b1;
        cycle();
        wait_ar(1, n);
        chk("single_rvalid", S1_RVALID, 1);
        chk("single_rlast", S1_RLAST, 1);
        chk("single_rdata", S1_RDATA, 32'hDEADBEEF);
        cycle();
        chk("single_idle_next", BUSY, 0);
        chk("single_grant_clear", GRANT, 2'b00);
        data_off = '0;

        // Slave holds ARREADY low for 20 cycles; request inputs wander meanwhile.
        ar_delay = 20;
        push_burst(0, 32'h4000, 3);
        S0_ARADDR = 32'h4000; S0_ARLEN = 8'd3; S0_ARVALID = 1'b1;
        cycle();
        S0_ARADDR = 32'hFFFF_0000; S0_ARLEN = 8'hAA;
        for (int c = 0; c < 20; c++) begin
            chk("arhold_stable", {M_AXI_ARVALID, S0_ARREADY, S1_ARREADY, M_AXI_ARLEN, M_AXI_ARADDR},
                {1'b1, 1'b0, 1'b0, 8'd3, 32'h4000});
            cycle();
        end
        wait_ar(0, n);
        chk("arhold_pulse_at_ready", n, 0);
        wait_idle();
        chk("arhold_sb_drained", sb.size(), 0);
        ar_delay = 0;

        // Reset lands while beat 10 of an S0 burst is on the bus.
        push_burst(0, 32'h5000, 31);
        S0_ARADDR = 32'h5000; S0_ARLEN = 8'h1F; S0_ARVALID = 1'b1;
        cycle();
        wait_ar(0, n);
        base = rx_cnt[0];
        n = 0;
        while (rx_cnt[0] - base < 10 && n < 100) begin
            cycle();
            n++;
        end
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        #1;
        chk("midrst_grant", GRANT, 2'b00);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_arvalid", M_AXI_ARVALID, 0);
        chk("midrst_rready_refuses", {M_AXI_RVALID, M_AXI_RREADY}, 2'b10);
        rq.delete();
        sb.delete();
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST = 1'b0;
        push_burst(1, 32'h6000, 3);
        S1_ARADDR = 32'h6000; S1_ARLEN = 8'd3; S1_ARVALID = 1'b1;
        cycle();
        chk("postrst_grant", GRANT, 2'b10);
        chk("postrst_araddr", M_AXI_ARADDR, 32'h6000);
        wait_ar(1, n);
        wait_idle();
        chk("postrst_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
